// File: rtl/srm_neuron_array.sv
// srm_neuron_array
//   Time-multiplexed leaky integrate-and-fire engine. One shared datapath
//   sweeps all NEURON_NO membrane potentials once per DT-cycle time step.
//   It applies leak, the pending input weight with saturation, per-neuron
//   thresholds and a refractory hold-off. Fired spikes are queued as
//   {dt_ts, neuron_addr} words in an output FIFO.
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   sys_en          : enables the time-step counter
//   in_valid/in_addr: inject an input spike (sets the neuron's pending bit)
//   w_in            : weight added for a pending input during the sweep
//   cfg_we/addr/data: threshold write (0 disables the neuron)
//   sp_valid/ready  : output FIFO handshake, sp_data = {dt_ts, addr}
//   dt_ts           : current time step
//   busy            : engine in INIT or SWEEP
//   sp_drop         : sticky, a spike was lost to a full FIFO
//   overrun         : sticky, a time-step tick arrived while not IDLE
module srm_neuron_array #(
  parameter int NEURON_NO      = 256,
  parameter int TS_WIDTH       = 16,
  parameter int DT             = 1000,
  parameter int MU_LEN         = 16,
  parameter int REFRACTORY_LEN = 4,
  parameter int REFRACTORY_PER = 4,
  parameter int LEAK_SHIFT     = 4,
  parameter int FIFO_DEPTH     = 16,
  localparam int AW            = $clog2(NEURON_NO)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sys_en,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_addr,
  input  logic [MU_LEN-1:0]      w_in,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [MU_LEN-1:0]      cfg_data,
  output logic                   sp_valid,
  input  logic                   sp_ready,
  output logic [TS_WIDTH+AW-1:0] sp_data,
  output logic [TS_WIDTH-1:0]    dt_ts,
  output logic                   busy,
  output logic                   sp_drop,
  output logic                   overrun
);

  localparam int CW  = (DT > 1) ? $clog2(DT) : 1;
  localparam int SW  = AW + 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int DW  = TS_WIDTH + AW;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  // ---------------- control state ----------------
  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       idx_q, idx_d;       // INIT address / sweep read index
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                drop_q, drop_d;
  logic                ovr_q, ovr_d;
  logic                count_en, dt_tick;

  // ---------------- neuron storage ----------------
  logic [MU_LEN-1:0]         mu_mem  [NEURON_NO];
  logic [REFRACTORY_LEN-1:0] ref_mem [NEURON_NO];
  logic [MU_LEN-1:0]         thr_mem [NEURON_NO];
  logic [NEURON_NO-1:0]      pend_q, pend_d;

  // ---------------- pipeline stage 1 ----------------
  logic                      s1_vld_q, s1_vld_d;
  logic [AW-1:0]             s1_addr_q;
  logic [MU_LEN-1:0]         s1_mu_q, s1_thr_q;
  logic [REFRACTORY_LEN-1:0] s1_ref_q;
  logic                      s1_pend_q;

  logic                      rd_en;
  logic [AW-1:0]             rd_addr;
  logic [MU_LEN-1:0]         leak;
  logic [MU_LEN:0]           sum;
  logic [MU_LEN-1:0]         mu_sat, wb_mu;
  logic [REFRACTORY_LEN-1:0] wb_ref;
  logic                      fire, spike_push;

  // ---------------- output FIFO ----------------
  logic [DW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FAW:0]   fcnt_q, fcnt_d;
  logic           pop, full, push_ok;

  assign count_en = sys_en && (state_q != ST_INIT);
  assign dt_tick  = count_en && (tcnt_q == CW'(DT - 1));

  // The sweep index runs 0..NEURON_NO; the top bit marks the final cycle,
  // which only carries stage 1 of the last neuron.
  assign rd_en   = (state_q == ST_SWEEP) && !idx_q[AW];
  assign rd_addr = idx_q[AW-1:0];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tcnt_d   = tcnt_q;
    ts_d     = ts_q;
    ovr_d    = ovr_q;
    s1_vld_d = rd_en;

    if (count_en) begin
      if (dt_tick) begin
        tcnt_d = '0;
        ts_d   = ts_q + TS_WIDTH'(1);
      end else begin
        tcnt_d = tcnt_q + CW'(1);
      end
    end
    if (dt_tick && (state_q != ST_IDLE)) ovr_d = 1'b1;

    case (state_q)
      ST_INIT: begin
        if (idx_q == SW'(NEURON_NO - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SW'(1);
        end
      end
      ST_IDLE: begin
        if (dt_tick) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_q[AW]) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pending bits are consumed at the stage-0 read; applying the injection
  // after the clear lets a same-cycle injection survive into the next step.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_INIT) begin
      pend_d[idx_q[AW-1:0]] = 1'b0;
    end else begin
      if (rd_en)    pend_d[rd_addr] = 1'b0;
      if (in_valid) pend_d[in_addr] = 1'b1;
    end
  end

  // Stage 1: leak, integrate with saturation, threshold and refractory.
  always_comb begin
    leak   = s1_mu_q >> LEAK_SHIFT;
    sum    = {1'b0, s1_mu_q - leak} + (s1_pend_q ? {1'b0, w_in} : '0);
    mu_sat = sum[MU_LEN] ? '1 : sum[MU_LEN-1:0];
    wb_mu  = mu_sat;
    wb_ref = s1_ref_q;
    fire   = 1'b0;
    if (s1_ref_q != '0) begin
      wb_ref = s1_ref_q - REFRACTORY_LEN'(1);
      wb_mu  = '0;
    end else if ((s1_thr_q != '0) && (mu_sat >= s1_thr_q)) begin
      fire   = 1'b1;
      wb_mu  = '0;
      wb_ref = REFRACTORY_LEN'(REFRACTORY_PER);
    end
  end

  assign spike_push = s1_vld_q && fire;

  // FIFO: a push into a full FIFO is still accepted when the head leaves
  // in the same cycle.
  assign sp_valid = (fcnt_q != '0);
  assign pop      = sp_valid && sp_ready;
  assign full     = (fcnt_q == (FAW+1)'(FIFO_DEPTH));
  assign push_ok  = spike_push && (!full || pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    drop_d = drop_q;
    if (push_ok) wr_d = wr_q + FAW'(1);
    if (pop)     rd_d = rd_q + FAW'(1);
    if (push_ok && !pop)      fcnt_d = fcnt_q + (FAW+1)'(1);
    else if (!push_ok && pop) fcnt_d = fcnt_q - (FAW+1)'(1);
    if (spike_push && !push_ok) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      tcnt_q    <= '0;
      ts_q      <= '0;
      drop_q    <= 1'b0;
      ovr_q     <= 1'b0;
      pend_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_mu_q   <= '0;
      s1_thr_q  <= '0;
      s1_ref_q  <= '0;
      s1_pend_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      ts_q      <= ts_d;
      drop_q    <= drop_d;
      ovr_q     <= ovr_d;
      pend_q    <= pend_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= rd_addr;
      s1_mu_q   <= mu_mem[rd_addr];
      s1_thr_q  <= thr_mem[rd_addr];
      s1_ref_q  <= ref_mem[rd_addr];
      s1_pend_q <= pend_q[rd_addr];
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Storage arrays carry no reset; INIT clears them one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mu_mem[idx_q[AW-1:0]]  <= '0;
      ref_mem[idx_q[AW-1:0]] <= '0;
      thr_mem[idx_q[AW-1:0]] <= '0;
    end else begin
      if (s1_vld_q) begin
        mu_mem[s1_addr_q]  <= wb_mu;
        ref_mem[s1_addr_q] <= wb_ref;
      end
      if (cfg_we) thr_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_q] <= {ts_q, s1_addr_q};
  end

  assign sp_data = sp_valid ? fifo_mem[rd_q] : '0;
  assign dt_ts   = ts_q;
  assign busy    = (state_q != ST_IDLE);
  assign sp_drop = drop_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_srm_neuron_array.sv
// tb_srm_neuron_array
//   Bench for srm_neuron_array with NEURON_NO=8, DT=16, MU_LEN=8,
//   LEAK_SHIFT=2, REFRACTORY_PER=4, FIFO_DEPTH=2. A second instance with a
//   DT shorter than the sweep exercises the overrun flag.
module tb_srm_neuron_array;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16 + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sys_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [7:0]    w_in = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic          sp_valid;
  logic          sp_ready = 1'b1;
  logic [DW-1:0] sp_data;
  logic [15:0]   dt_ts;
  logic          busy, sp_drop, overrun;

  logic          o_sys_en = 1'b0;
  logic          o_sp_valid;
  logic [DW-1:0] o_sp_data;
  logic [15:0]   o_dt_ts;
  logic          o_busy, o_sp_drop, o_overrun;

  always #5 clk = ~clk;

  srm_neuron_array #(
    .NEURON_NO(8), .TS_WIDTH(16), .DT(16), .MU_LEN(8), .REFRACTORY_LEN(4),
    .REFRACTORY_PER(4), .LEAK_SHIFT(2), .FIFO_DEPTH(2)
  ) u_dut (
    .clk(clk), .reset(reset), .sys_en(sys_en), .in_valid(in_valid),
    .in_addr(in_addr), .w_in(w_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sp_valid(sp_valid), .sp_ready(sp_ready),
    .sp_data(sp_data), .dt_ts(dt_ts), .busy(busy), .sp_drop(sp_drop),
    .overrun(overrun)
  );

  // DT=8 is shorter than the 9-cycle sweep, so a tick lands inside SWEEP.
  srm_neuron_array #(
    .NEURON_NO(8), .TS_WIDTH(16), .DT(8), .MU_LEN(8), .REFRACTORY_LEN(4),
    .REFRACTORY_PER(4), .LEAK_SHIFT(2), .FIFO_DEPTH(2)
  ) u_ovr (
    .clk(clk), .reset(reset), .sys_en(o_sys_en), .in_valid(in_valid),
    .in_addr(in_addr), .w_in(w_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sp_valid(o_sp_valid), .sp_ready(1'b1),
    .sp_data(o_sp_data), .dt_ts(o_dt_ts), .busy(o_busy), .sp_drop(o_sp_drop),
    .overrun(o_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0]   exp_ts;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] exp_q [$];

  // reference model state
  int m_mu  [N];
  int m_ref [N];
  int m_thr [N];
  bit m_pend [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: collects transferred words and checks the head holds
  // steady while it is stalled.
  initial begin
    logic          hold;
    logic [DW-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold && sp_valid) check("sp_data_hold", sp_data, held);
        if (sp_valid && sp_ready) got_q.push_back(sp_data);
        hold = sp_valid && !sp_ready;
        held = sp_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic compare_got();
    int n;
    check("word_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("spike_word", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_words(input logic [7:0] mask, input logic [15:0] ts);
    for (int k = 0; k < N; k++) if (mask[k]) exp_q.push_back({ts, 3'(k)});
    compare_got();
  endtask

  task automatic do_reset(input string tag);
    int c;
    drv();
    reset = 1'b1; sys_en = 1'b0; o_sys_en = 1'b0; in_valid = 1'b0;
    cfg_we = 1'b0; sp_ready = 1'b1;
    drv();
    @(negedge clk);
    check({tag, "_rst_busy"}, busy, 1);
    check({tag, "_rst_sp_valid"}, sp_valid, 0);
    check({tag, "_rst_sp_data"}, sp_data, 0);
    check({tag, "_rst_dt_ts"}, dt_ts, 0);
    check({tag, "_rst_sp_drop"}, sp_drop, 0);
    check({tag, "_rst_overrun"}, overrun, 0);
    check({tag, "_rst_ovr_busy"}, o_busy, 1);
    drv();
    reset = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) c++;
      else break;
    end
    check({tag, "_init_len"}, c, 8);
    check({tag, "_post_init_valid"}, sp_valid, 0);
    check({tag, "_post_init_ts"}, dt_ts, 0);
    got_q.delete();
    exp_q.delete();
    exp_ts = '0;
  endtask

  task automatic cfg_thr(input logic [7:0] mask, input logic [7:0] val);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        drv();
        cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = val;
      end
    end
    drv();
    cfg_we = 1'b0;
  endtask

  // One time step: injections while the counter is frozen, then let one
  // tick through and follow the sweep. first_v is the sweep cycle at which
  // sp_valid was first seen (-1 if never). inj_cyc >= 0 injects inj_a
  // during that sweep cycle.
  task automatic do_step(input logic [7:0] inj, input logic [7:0] w, input logic rdy,
                         input int inj_cyc, input logic [AW-1:0] inj_a, output int first_v);
    int c;
    bit found;
    first_v = -1;
    for (int i = 0; i < N; i++) begin
      if (inj[i]) begin
        drv();
        in_valid = 1'b1; in_addr = 3'(i);
      end
    end
    drv();
    in_valid = 1'b0; w_in = w; sp_ready = rdy; sys_en = 1'b1;
    exp_ts = exp_ts + 16'd1;
    found = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    check("tick_wait", found, 1);
    if (found) begin
      check("dt_ts", dt_ts, exp_ts);
      c = 0;
      while (c < 40) begin
        if (first_v < 0 && sp_valid) first_v = c;
        if (!busy) break;
        @(posedge clk);
        #1;
        in_valid = (c + 1 == inj_cyc);
        in_addr  = inj_a;
        @(negedge clk);
        c++;
      end
      check("sweep_len", c, 9);
    end
    drv();
    sys_en = 1'b0; in_valid = 1'b0;
    repeat (4) drv();
    if (!rdy) begin
      check("stall_no_xfer", got_q.size(), 0);
      check("stall_valid", sp_valid, 1);
      sp_ready = 1'b1;
      repeat (4) drv();
      check("drained_valid", sp_valid, 0);
    end
  endtask

  task automatic model_step(input logic [7:0] w);
    int v;
    for (int k = 0; k < N; k++) begin
      if (m_ref[k] != 0) begin
        m_ref[k] = m_ref[k] - 1;
        m_mu[k]  = 0;
      end else begin
        v = m_mu[k] - m_mu[k] / 4 + (m_pend[k] ? int'(w) : 0);
        if (v > 255) v = 255;
        if (m_thr[k] != 0 && v >= m_thr[k]) begin
          exp_q.push_back({exp_ts, 3'(k)});
          m_mu[k]  = 0;
          m_ref[k] = 4;
        end else begin
          m_mu[k] = v;
        end
      end
      m_pend[k] = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] cfg_mask;
    logic [7:0] cfg_val;
    logic [7:0] inj;
    logic [7:0] w;
    logic       rdy;
    logic [7:0] exp_mask;
    logic       exp_drop;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int fv;
    bit found;
    logic [7:0] inj, w;

    tbl[0]  = '{8'h08, 8'd100, 8'h08, 8'd64,  1'b1, 8'h00, 1'b0}; // mu3 = 64
    tbl[1]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h08, 1'b0}; // 112 >= 100
    tbl[2]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h00, 1'b0}; // ref 4->3
    tbl[3]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h00, 1'b0};
    tbl[4]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h00, 1'b0};
    tbl[5]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h00, 1'b0}; // ref 1->0
    tbl[6]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h00, 1'b0}; // mu3 = 64
    tbl[7]  = '{8'h00, 8'd0,   8'h08, 8'd64,  1'b1, 8'h08, 1'b0}; // 112 again
    tbl[8]  = '{8'h10, 8'd0,   8'h10, 8'd255, 1'b1, 8'h00, 1'b0}; // n4 disabled
    tbl[9]  = '{8'h00, 8'd0,   8'h10, 8'd255, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{8'h00, 8'd0,   8'h10, 8'd255, 1'b1, 8'h00, 1'b0}; // mu4 = 255
    tbl[11] = '{8'h10, 8'd255, 8'h10, 8'd255, 1'b1, 8'h10, 1'b0}; // sat >= 255
    tbl[12] = '{8'h26, 8'd10,  8'h26, 8'd64,  1'b0, 8'h06, 1'b1}; // n5 dropped

    do_reset("first");

    // thresholds unset: nothing fires even when fully driven
    for (int s = 0; s < 3; s++) begin
      do_step(8'hFF, 8'd255, 1'b1, -1, '0, fv);
      check("unset_thr_valid", fv, -1);
      check_words(8'h00, exp_ts);
    end

    do_reset("second");
    for (int r = 0; r < 13; r++) begin
      if (tbl[r].cfg_mask != 8'h00) cfg_thr(tbl[r].cfg_mask, tbl[r].cfg_val);
      do_step(tbl[r].inj, tbl[r].w, tbl[r].rdy, -1, '0, fv);
      if (tbl[r].exp_mask != 8'h00) check("spike_latency", fv, lowest(tbl[r].exp_mask) + 2);
      else check("no_spike_valid", fv, -1);
      check_words(tbl[r].exp_mask, exp_ts);
      check("sp_drop", sp_drop, tbl[r].exp_drop);
      check("overrun_main", overrun, 0);
    end

    // injection collides with the sweep clear of the same neuron
    cfg_thr(8'h40, 8'd10);
    do_step(8'h00, 8'd64, 1'b1, 6, 3'd6, fv);
    check_words(8'h00, exp_ts);
    do_step(8'h00, 8'd64, 1'b1, -1, '0, fv);
    check("collide_latency", fv, 8);
    check_words(8'h40, exp_ts);

    // randomized steps against the reference model
    do_reset("random");
    for (int k = 0; k < N; k++) begin
      m_mu[k] = 0; m_ref[k] = 0; m_pend[k] = 1'b0;
      m_thr[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(20, 200));
      cfg_thr(8'(1 << k), 8'(m_thr[k]));
    end
    for (int s = 0; s < 20; s++) begin
      inj = 8'($urandom_range(0, 255));
      w   = 8'($urandom_range(0, 255));
      for (int k = 0; k < N; k++) if (inj[k]) m_pend[k] = 1'b1;
      do_step(inj, w, 1'b1, -1, '0, fv);
      model_step(w);
      compare_got();
      check("rand_drop", sp_drop, 0);
    end

    // reset in the middle of a sweep
    drv();
    sys_en = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    check("midsweep_tick_wait", found, 1);
    repeat (3) @(negedge clk);
    do_reset("midsweep");

    // tick during SWEEP on the short-DT instance
    check("ovr_before", o_overrun, 0);
    drv();
    o_sys_en = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (o_overrun) begin
        found = 1'b1;
        break;
      end
    end
    check("overrun_set", found, 1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", o_overrun, 1);
    check("ovr_ts_moving", (o_dt_ts != 16'd0), 1);
    check("ovr_no_spikes", {o_sp_valid, o_sp_drop, (o_sp_data != '0)}, 0);
    check("overrun_main_clear", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srm_neuron_array.md
# srm_neuron_array

Parametrised, time-multiplexed neuron update engine: a single datapath sweeps all `NEURON_NO` membrane potentials once per `DT`-cycle time step. It applies leaky integration, per-neuron thresholds and refractory hold-off, and streams fired spikes as `{timestamp, address}` words through an output FIFO with a valid/ready handshake. It supersedes the fixed single-output neuron pipeline. It adds external spike injection, runtime threshold configuration, saturation and back-pressure handling.

## Interface
- `NEURON_NO`, 256: neuron count, power of two ≥ 4; `AW = $clog2(NEURON_NO)`.
- `TS_WIDTH`, 16: timestamp width.
- `DT`, 1000: cycles per time step; must exceed `NEURON_NO + 2`.
- `MU_LEN`, 16: membrane potential, threshold and weight width (unsigned).
- `REFRACTORY_LEN`, 4: refractory counter width.
- `REFRACTORY_PER`, 4: steps held after a spike; must be < 2^REFRACTORY_LEN.
- `LEAK_SHIFT`, 4: leak is `mu >> LEAK_SHIFT` per step.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two.

Ports:
- `clk`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-high.
- `sys_en`, in, 1: enables the time-step counter.
- `in_valid`, in, 1: inject one input spike for `in_addr`.
- `in_addr`, in, AW: target neuron of the injected spike.
- `w_in`, in, MU_LEN: synaptic weight added per pending input.
- `cfg_we`, in, 1: threshold write strobe.
- `cfg_addr`, in, AW: threshold write address.
- `cfg_data`, in, MU_LEN: threshold value; 0 disables the neuron.
- `sp_valid`, out, 1: FIFO head valid.
- `sp_ready`, in, 1: consumer accepts the head.
- `sp_data`, out, TS_WIDTH+AW: `{dt_ts, neuron_addr}`.
- `dt_ts`, out, TS_WIDTH: current time step.
- `busy`, out, 1: high in INIT or SWEEP.
- `sp_drop`, out, 1: sticky; a spike was lost because the FIFO was full.
- `overrun`, out, 1: sticky; a tick arrived while the engine was not IDLE.

## Operation
- Storage per neuron: `mu` (MU_LEN), `ref` (REFRACTORY_LEN), `thr` (MU_LEN) and a `pending` bit.
- FSM INIT: entered on reset. Walks addresses 0..NEURON_NO-1, clearing `mu`, `ref`, `thr` and `pending`, one per cycle, then goes to IDLE. `cfg_we` and `in_valid` are ignored in INIT.
- Time-step counter: counts only in IDLE/SWEEP with `sys_en`=1. `dt_tick` fires at count `DT-1`; the count then wraps to 0 and `dt_ts` increments, wrapping modulo 2^TS_WIDTH.
- FSM IDLE → SWEEP on `dt_tick`.
- FSM SWEEP: stage 0 reads neuron k at sweep cycle k; stage 1 computes and writes back at cycle k+1. The FSM returns to IDLE after stage 1 of neuron NEURON_NO-1.
- A `dt_tick` that arrives outside IDLE is ignored and sets `overrun`.
- Update rule, case `ref` ≠ 0: `ref` ← `ref`-1, `mu` ← 0, `pending` is cleared and discarded, no spike.
- Update rule, otherwise: `mu_n = mu - (mu>>LEAK_SHIFT) + (pending ? w_in : 0)`, saturating at 2^MU_LEN-1, and `pending` is cleared.
  - If `thr` ≠ 0 and `mu_n` ≥ `thr`: spike, `mu` ← 0, `ref` ← REFRACTORY_PER.
  - Otherwise `mu` ← `mu_n`.
- Injection: `in_valid` sets `pending[in_addr]`. Multiple injections within one step count once. If an injection and the sweep clear hit the same address in the same cycle, the set wins and the spike applies next step.
- Config: `cfg_we` writes `thr` at any time outside INIT. The engine reads before the write, so a same-cycle read of `cfg_addr` sees the old value.
- Spike output: each spike pushes `{dt_ts, k}`. If the FIFO is full, the entry is dropped and `sp_drop` is set. `sp_drop` and `overrun` clear only on reset.

## Timing
- Reset values:
  - `sp_valid`=0, `sp_data`=0, `dt_ts`=0;
  - `busy`=1, because INIT starts immediately;
  - `sp_drop`=0, `overrun`=0;
  - the counter is 0.
- INIT lasts exactly NEURON_NO cycles after reset deasserts.
- The timestamp of a spike is the `dt_ts` value after the increment that started the sweep.
- Spike latency: the FIFO write happens at the end of sweep cycle k+1. `sp_valid` rises in cycle k+2 when the FIFO was empty.
- A simultaneous push and pop on a full FIFO succeeds with no drop.
- Handshake: transfer occurs when `sp_valid` & `sp_ready`. `sp_data` holds stable while `sp_valid`=1 and `sp_ready`=0.
- Reset asserted mid-sweep: all state aborts immediately, and the FIFO and pending bits are lost.

## Test plan
Common settings: NEURON_NO=8, DT=16, MU_LEN=8, LEAK_SHIFT=2, REFRACTORY_PER=4, FIFO_DEPTH=2.
- Reset, then 8 INIT cycles → `busy`=1 for 8 cycles then 0, all outputs 0, and no spike for 3 steps even with `thr` unset.
- `thr[3]`=100, `w_in`=64, inject n3 before two consecutive steps:
  - first step: `mu`=64, no spike;
  - second step: `mu_n`=112 → `sp_data`={2,3}, `sp_valid` two cycles after n3's read.
- After that spike, inject n3 before each of the next 5 steps → no spike for 4 steps (`ref` 4→0); the 5th step gives `mu`=64.
- `thr` of n1, n2 and n5 = 10, all injected in one step, `sp_ready`=0 → FIFO holds {ts,1},{ts,2}, `sp_drop`=1. Raise `sp_ready` → exactly 2 words in order.
- `thr[4]`=0, `w_in`=255, inject n4 for 3 steps → `mu` stays 255 (saturated), never spikes. Inject and sweep-clear on the same address in the same cycle → applied next step.
- Force `DT` short relative to the sweep (tick while SWEEP) → `overrun`=1. Assert `reset` mid-sweep → outputs return to reset values and INIT restarts.
